// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder behind the MEM stage load/store port.
// Optional access counters are enabled with `define DMEM_ACCESS_COUNT_EN.
module dmem_responder #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [7:0]  req_strobe,
  input  logic [63:0] req_data,
  output logic        resp_ok,
  output logic        resp_err,
  output logic [63:0] resp_data,
  output logic        busy
`ifdef DMEM_ACCESS_COUNT_EN
  ,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
`endif
);

  localparam int unsigned Depth = 2 ** (ADDR_WIDTH - 3);

  if (LATENCY < 1 || LATENCY > 15) begin : g_latency_check
    $error("dmem_responder: LATENCY must be in 1..15");
  end

  if (ADDR_WIDTH < 4 || ADDR_WIDTH > 32) begin : g_addr_width_check
    $error("dmem_responder: ADDR_WIDTH must be in 4..32");
  end

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  state_e                  state_q;
  logic [3:0]              cnt_q;
  logic                    write_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [2:0]              size_q;
  logic [7:0]              strobe_q;
  logic [63:0]             data_q;

  logic [63:0]             mem [Depth];

  logic                    addr_err;
  logic                    access;
  logic                    mem_we;
  logic [ADDR_WIDTH-4:0]   idx;

  // Address bits above ADDR_WIDTH are deliberately ignored so accesses wrap.
  logic                    unused_addr_hi;
  assign unused_addr_hi = ^req_addr[63:ADDR_WIDTH];

  assign idx = addr_q[ADDR_WIDTH-1:3];

  always_comb begin
    addr_err = 1'b0;
    case (size_q)
      3'd0:    addr_err = 1'b0;
      3'd1:    addr_err = addr_q[0];
      3'd2:    addr_err = |addr_q[1:0];
      3'd3:    addr_err = |addr_q[2:0];
      default: addr_err = 1'b1;
    endcase
  end

  // The access happens on the edge that leaves WAIT; reset on that edge cancels it.
  assign access = (state_q == StWait) && (cnt_q == 4'd0) && !reset;
  assign mem_we = access && write_q && !addr_err;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 8; i++) begin
        if (strobe_q[i]) begin
          mem[idx][8*i +: 8] <= data_q[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      size_q    <= 3'd0;
      strobe_q  <= 8'd0;
      data_q    <= 64'd0;
      resp_ok   <= 1'b0;
      resp_err  <= 1'b0;
      resp_data <= 64'd0;
      busy      <= 1'b0;
`ifdef DMEM_ACCESS_COUNT_EN
      rd_count  <= 32'd0;
      wr_count  <= 32'd0;
`endif
    end else begin
      resp_ok   <= 1'b0;
      resp_err  <= 1'b0;
      resp_data <= 64'd0;
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            write_q  <= req_write;
            addr_q   <= req_addr[ADDR_WIDTH-1:0];
            size_q   <= req_size;
            strobe_q <= req_strobe;
            data_q   <= req_data;
            cnt_q    <= 4'(LATENCY - 1);
            state_q  <= StWait;
            busy     <= 1'b1;
          end
        end
        StWait: begin
          if (cnt_q == 4'd0) begin
            state_q  <= StResp;
            resp_ok  <= 1'b1;
            resp_err <= addr_err;
            if (!write_q && !addr_err) begin
              resp_data <= mem[idx];
            end
`ifdef DMEM_ACCESS_COUNT_EN
            if (!addr_err) begin
              if (write_q) begin
                wr_count <= wr_count + 32'd1;
              end else begin
                rd_count <= rd_count + 32'd1;
              end
            end
`endif
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        // Always pass through IDLE so a still-held request is not taken twice in a row.
        StResp: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed cases plus random traffic
// against an array-based reference model.
module tb_dmem_responder;

  localparam int unsigned AW  = 12;
  localparam int unsigned LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [63:0] req_addr;
  logic [2:0]  req_size;
  logic [7:0]  req_strobe;
  logic [63:0] req_data;
  logic        resp_ok;
  logic        resp_err;
  logic [63:0] resp_data;
  logic        busy;
`ifdef DMEM_ACCESS_COUNT_EN
  logic [31:0] rd_count;
  logic [31:0] wr_count;
`endif

  always #5 clk = ~clk;

  dmem_responder #(
    .ADDR_WIDTH(AW),
    .LATENCY   (LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_size  (req_size),
    .req_strobe(req_strobe),
    .req_data  (req_data),
    .resp_ok   (resp_ok),
    .resp_err  (resp_err),
    .resp_data (resp_data),
    .busy      (busy)
`ifdef DMEM_ACCESS_COUNT_EN
    ,
    .rd_count  (rd_count),
    .wr_count  (wr_count)
`endif
  );

  logic [63:0] model [2 ** (AW - 3)];
  int unsigned rd_model;
  int unsigned wr_model;
  int          vectors;
  int          miscompares;

  function automatic bit is_err(input logic [63:0] a, input logic [2:0] s);
    if (s > 3'd3) return 1'b1;
    return (a % (64'd1 << s)) != 64'd0;
  endfunction

  function automatic int word_of(input logic [63:0] a);
    return int'((a % (64'd1 << AW)) / 64'd8);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request, held until the response; req_* are scrambled after acceptance.
  task automatic transact(input bit w, input logic [63:0] a, input logic [2:0] s,
                          input logic [7:0] st, input logic [63:0] d);
    logic [63:0] exp_data;
    bit          err;
    int          wi;
    err      = is_err(a, s);
    wi       = word_of(a);
    exp_data = (!w && !err) ? model[wi] : 64'd0;
    @(posedge clk);
    #1;
    req_valid  = 1'b1;
    req_write  = w;
    req_addr   = a;
    req_size   = s;
    req_strobe = st;
    req_data   = d;
    for (int k = 0; k <= int'(LAT) + 1; k++) begin
      @(negedge clk);
      check("resp_ok", 64'(resp_ok), 64'(k == int'(LAT) + 1));
      check("busy", 64'(busy), 64'(k != 0));
      if (k == int'(LAT) + 1) begin
        check("resp_err", 64'(resp_err), 64'(err));
        check("resp_data", resp_data, exp_data);
      end else begin
        check("resp_err_idle", 64'(resp_err), 64'd0);
      end
      @(posedge clk);
      #1;
      if (k == int'(LAT) + 1) begin
        req_valid = 1'b0;
      end else begin
        req_write  = ~req_write;
        req_addr   = {$urandom, $urandom};
        req_size   = 3'($urandom);
        req_strobe = 8'($urandom);
        req_data   = {$urandom, $urandom};
      end
    end
    if (!err) begin
      if (w) begin
        for (int i = 0; i < 8; i++) begin
          if (st[i]) model[wi][8*i +: 8] = d[8*i +: 8];
        end
        wr_model++;
      end else begin
        rd_model++;
      end
    end
  endtask

  task automatic check_counts(input string tag);
`ifdef DMEM_ACCESS_COUNT_EN
    check({tag, "_rd_count"}, 64'(rd_count), 64'(rd_model));
    check({tag, "_wr_count"}, 64'(wr_count), 64'(wr_model));
`else
    if (tag.len() == 0) $display("counters absent");
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] a;
    logic [2:0]  s;
    int          per;
    vectors     = 0;
    miscompares = 0;
    rd_model    = 0;
    wr_model    = 0;
    for (int i = 0; i < 2 ** (AW - 3); i++) model[i] = 64'd0;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = 64'd0;
    req_size   = 3'd0;
    req_strobe = 8'd0;
    req_data   = 64'd0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_resp_ok", 64'(resp_ok), 64'd0);
    check("rst_resp_err", 64'(resp_err), 64'd0);
    check("rst_resp_data", resp_data, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check_counts("rst");

    // Basic store/load, partial store, misaligned accesses.
    transact(1'b1, 64'h10, 3'd3, 8'hFF, 64'h1122334455667788);
    transact(1'b0, 64'h10, 3'd3, 8'h00, 64'd0);
    check("model_basic", model[2], 64'h1122334455667788);
    transact(1'b1, 64'h14, 3'd2, 8'hF0, 64'hAABBCCDD00000000);
    transact(1'b0, 64'h10, 3'd3, 8'h00, 64'd0);
    transact(1'b0, 64'h13, 3'd1, 8'h00, 64'd0);
    transact(1'b1, 64'h11, 3'd2, 8'hFF, 64'hDEADBEEFDEADBEEF);
    transact(1'b0, 64'h10, 3'd3, 8'h00, 64'd0);
    transact(1'b1, 64'h18, 3'd3, 8'h00, 64'hFFFFFFFFFFFFFFFF);
    transact(1'b0, 64'h18, 3'd5, 8'h00, 64'd0);
    check_counts("directed");

    // Held request: one response every LAT+2 cycles, IDLE once per period.
    per = int'(LAT) + 2;
    @(posedge clk);
    #1;
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_addr   = 64'h10;
    req_size   = 3'd3;
    req_strobe = 8'h00;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("held_resp_ok", 64'(resp_ok), 64'((c % per) == int'(LAT) + 1));
      check("held_busy", 64'(busy), 64'((c % per) != 0));
      if ((c % per) == int'(LAT) + 1) begin
        check("held_resp_data", resp_data, model[2]);
        rd_model++;
      end
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    check_counts("held");

    // Reset while in WAIT drops the pending store and the response.
    @(posedge clk);
    #1;
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_addr   = 64'h20;
    req_size   = 3'd3;
    req_strobe = 8'hFF;
    req_data   = 64'hCAFEF00D12345678;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    req_valid = 1'b0;
    rd_model  = 0;
    wr_model  = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("rstwait_resp_ok", 64'(resp_ok), 64'd0);
      check("rstwait_busy", 64'(busy), 64'd0);
      @(posedge clk);
      #1;
    end

    // Address wrap modulo 2^AW.
    transact(1'b1, 64'h1008, 3'd3, 8'hFF, 64'h0F1E2D3C4B5A6978);
    transact(1'b0, 64'h0008, 3'd3, 8'h00, 64'd0);
    check_counts("wrap");
    transact(1'b0, 64'h20, 3'd3, 8'h00, 64'd0);

    // Random traffic over a few words, with random upper address bits.
    for (int n = 0; n < 60; n++) begin
      a = (64'($urandom_range(0, 15)) << AW) | 64'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) a = a | (64'($urandom) << 32);
      s = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      transact(1'($urandom), a, s, 8'($urandom), {$urandom, $urandom});
    end
    check_counts("random");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
